// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard unit: register addresses, stage write
// enables, branch/multi-cycle handshake in; forward selects, stalls, flushes out.
interface pipe_hazard_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int AW      = 5,
  parameter int CNT_W   = 32
);
  logic [NUM_SRC*AW-1:0] rs_d;
  logic [NUM_SRC-1:0]    rs_used_d;
  logic [NUM_SRC*AW-1:0] rs_e;
  logic [AW-1:0]         rd_e, rd_m, rd_w;
  logic                  regwrite_e, regwrite_m, regwrite_w;
  logic                  load_e;
  logic                  pcsrc_e;
  logic                  mc_start_e;
  logic                  mc_done;
  logic [2*NUM_SRC-1:0]  fwd_e;
  logic                  stall_f, stall_d, stall_e;
  logic                  flush_d, flush_e, flush_m;
  logic                  mc_timeout;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  modport master (
    output rs_d, rs_used_d, rs_e, rd_e, rd_m, rd_w,
           regwrite_e, regwrite_m, regwrite_w, load_e, pcsrc_e, mc_start_e, mc_done,
    input  fwd_e, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           mc_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs_d, rs_used_d, rs_e, rd_e, rd_m, rd_w,
           regwrite_e, regwrite_m, regwrite_w, load_e, pcsrc_e, mc_start_e, mc_done,
    output fwd_e, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           mc_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/pipeline control for the 5-stage core: operand forwarding, load-use
// stall, branch flush, multi-cycle execute stall with watchdog, perf counters.
module pipe_hazard_ctrl #(
  parameter int NUM_SRC    = 2,
  parameter int AW         = 5,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int BW = $clog2(MC_TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, stateNext;
  logic [BW-1:0]        busyCnt;
  logic                 mcStall, loadUse, timeoutHit, mcStartOk;
  logic                 stallF, mcTimeout;
  logic [2*NUM_SRC-1:0] fwd;
  logic [CNT_W-1:0]     stallCnt, flushCnt;

  always_comb begin
    fwd = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (bus.regwrite_m && bus.rd_m != '0 && bus.rd_m == bus.rs_e[i*AW +: AW])
        fwd[2*i +: 2] = 2'd1;
      else if (bus.regwrite_w && bus.rd_w != '0 && bus.rd_w == bus.rs_e[i*AW +: AW])
        fwd[2*i +: 2] = 2'd2;
    end
  end

  always_comb begin
    loadUse = 1'b0;
    if (bus.load_e && bus.regwrite_e && bus.rd_e != '0) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (bus.rs_used_d[i] && bus.rs_d[i*AW +: AW] == bus.rd_e)
          loadUse = 1'b1;
      end
    end
  end

  // A redirect in the same cycle cancels the multi-cycle request outright.
  assign mcStartOk  = bus.mc_start_e && !bus.pcsrc_e;
  assign timeoutHit = (state == BUSY) && !bus.mc_done && (busyCnt == BW'(MC_TIMEOUT - 1));

  always_comb begin
    stateNext = state;
    mcStall   = 1'b0;
    case (state)
      IDLE: begin
        if (mcStartOk && !bus.mc_done) begin
          mcStall   = 1'b1;
          stateNext = BUSY;
        end
      end
      BUSY: begin
        if (bus.mc_done || timeoutHit) stateNext = IDLE;
        else                           mcStall   = 1'b1;
      end
    endcase
  end

  assign stallF = !rst && (mcStall || (loadUse && !bus.pcsrc_e));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busyCnt   <= '0;
      mcTimeout <= 1'b0;
      stallCnt  <= '0;
      flushCnt  <= '0;
    end else begin
      state   <= stateNext;
      busyCnt <= (state == BUSY && stateNext == BUSY) ? busyCnt + 1'b1 : '0;
      if (timeoutHit)
        mcTimeout <= 1'b1;
      if (stallF && stallCnt != '1)
        stallCnt <= stallCnt + 1'b1;
      if (bus.pcsrc_e && flushCnt != '1)
        flushCnt <= flushCnt + 1'b1;
    end
  end

  // Combinational controls are forced quiet while reset is held.
  assign bus.fwd_e      = rst ? '0 : fwd;
  assign bus.stall_f    = stallF;
  assign bus.stall_d    = stallF;
  assign bus.stall_e    = !rst && mcStall;
  assign bus.flush_d    = !rst && bus.pcsrc_e;
  assign bus.flush_e    = !rst && !mcStall && (bus.pcsrc_e || loadUse);
  assign bus.flush_m    = !rst && mcStall;
  assign bus.mc_timeout = mcTimeout;
  assign bus.stall_cnt  = stallCnt;
  assign bus.flush_cnt  = flushCnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a cycle-level
// reference model of the hazard rules.
module tb_pipe_hazard_ctrl;
  localparam int NS  = 2;
  localparam int AW  = 5;
  localparam int TMO = 8;
  localparam int CW  = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam logic [5:0] MC_CTL = 6'b111001;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NUM_SRC(NS), .AW(AW), .CNT_W(CW)) bus();

  pipe_hazard_ctrl #(.NUM_SRC(NS), .AW(AW), .MC_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}
  logic [5:0] ctl;
  assign ctl = {bus.stall_f, bus.stall_d, bus.stall_e, bus.flush_d, bus.flush_e, bus.flush_m};

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // reference model state
  bit mActive;
  int mAge;
  bit mTimeout;
  int mStallCnt, mFlushCnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    bus.rs_d       = '0;
    bus.rs_used_d  = '0;
    bus.rs_e       = '0;
    bus.rd_e       = '0;
    bus.rd_m       = '0;
    bus.rd_w       = '0;
    bus.regwrite_e = 1'b0;
    bus.regwrite_m = 1'b0;
    bus.regwrite_w = 1'b0;
    bus.load_e     = 1'b0;
    bus.pcsrc_e    = 1'b0;
    bus.mc_start_e = 1'b0;
    bus.mc_done    = 1'b0;
  endtask

  task automatic resetPulse();
    @(negedge clk);
    clearInputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic setLoadUse(input logic [NS-1:0] used);
    bus.load_e         = 1'b1;
    bus.regwrite_e     = 1'b1;
    bus.rd_e           = 5'd7;
    bus.rs_d[AW +: AW] = 5'd7;
    bus.rs_used_d      = used;
  endtask

  task automatic randomCycle();
    logic [2*NS-1:0] expFwd;
    logic [AW-1:0]   rs;
    bit lu, mcs, sf;
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      bus.rs_d[i*AW +: AW] = AW'($urandom_range(0, 3));
      bus.rs_e[i*AW +: AW] = AW'($urandom_range(0, 3));
    end
    bus.rs_used_d  = NS'($urandom);
    bus.rd_e       = AW'($urandom_range(0, 3));
    bus.rd_m       = AW'($urandom_range(0, 3));
    bus.rd_w       = AW'($urandom_range(0, 3));
    bus.regwrite_e = 1'($urandom_range(0, 1));
    bus.regwrite_m = 1'($urandom_range(0, 1));
    bus.regwrite_w = 1'($urandom_range(0, 1));
    bus.load_e     = ($urandom_range(0, 2) == 0);
    bus.pcsrc_e    = !mActive && ($urandom_range(0, 7) == 0);
    bus.mc_start_e = ($urandom_range(0, 5) == 0);
    bus.mc_done    = ($urandom_range(0, 3) == 0);
    #1;
    expFwd = '0;
    lu = 0;
    for (int i = 0; i < NS; i++) begin
      rs = bus.rs_e[i*AW +: AW];
      if (bus.regwrite_m && bus.rd_m != 0 && bus.rd_m == rs)      expFwd[2*i +: 2] = 2'd1;
      else if (bus.regwrite_w && bus.rd_w != 0 && bus.rd_w == rs) expFwd[2*i +: 2] = 2'd2;
      if (bus.load_e && bus.regwrite_e && bus.rd_e != 0 && bus.rs_used_d[i] &&
          bus.rs_d[i*AW +: AW] == bus.rd_e)
        lu = 1;
    end
    if (!mActive) mcs = bus.mc_start_e && !bus.pcsrc_e && !bus.mc_done;
    else          mcs = !bus.mc_done && (mAge < TMO);
    sf = mcs || (lu && !bus.pcsrc_e);
    chk("rnd_fwd", bus.fwd_e, expFwd);
    chk("rnd_ctl", ctl, {sf, sf, mcs, bus.pcsrc_e, !mcs && (bus.pcsrc_e || lu), mcs});
    chk("rnd_timeout", bus.mc_timeout, mTimeout);
    chk("rnd_stall_cnt", bus.stall_cnt, mStallCnt);
    chk("rnd_flush_cnt", bus.flush_cnt, mFlushCnt);
    if (sf && mStallCnt < CNT_MAX) mStallCnt++;
    if (bus.pcsrc_e && mFlushCnt < CNT_MAX) mFlushCnt++;
    if (!mActive) begin
      if (mcs) begin
        mActive = 1;
        mAge    = 1;
      end
    end else if (bus.mc_done) begin
      mActive = 0;
    end else if (mAge == TMO) begin
      mActive  = 0;
      mTimeout = 1;
    end else begin
      mAge++;
    end
  endtask

  initial begin
    // reset holds every output low even with hazards present on the inputs
    rst = 1'b1;
    clearInputs();
    setLoadUse(2'b11);
    bus.pcsrc_e    = 1'b1;
    bus.mc_start_e = 1'b1;
    bus.rs_e[0 +: AW] = 5'd5;
    bus.rd_m       = 5'd5;
    bus.regwrite_m = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_ctl", ctl, 6'b0);
    chk("rst_fwd", bus.fwd_e, 0);
    chk("rst_stall_cnt", bus.stall_cnt, 0);
    chk("rst_flush_cnt", bus.flush_cnt, 0);
    chk("rst_timeout", bus.mc_timeout, 0);

    // forwarding priority and x0
    @(negedge clk);
    clearInputs();
    rst = 1'b0;
    bus.rs_e[0 +: AW] = 5'd5;
    bus.rd_m = 5'd5; bus.regwrite_m = 1'b1;
    bus.rd_w = 5'd5; bus.regwrite_w = 1'b1;
    #1;
    chk("fwd_m_prio", bus.fwd_e[1:0], 1);
    bus.rs_e[AW +: AW] = 5'd9;
    bus.rd_w = 5'd9;
    #1;
    chk("fwd_w_op1", bus.fwd_e, 4'b1001);
    bus.rd_m = 5'd0; bus.rd_w = 5'd0;
    bus.rs_e[0 +: AW] = 5'd0;
    #1;
    chk("fwd_x0", bus.fwd_e, 0);

    // load-use: one stall cycle, then forwarding from M
    resetPulse();
    @(negedge clk);
    clearInputs();
    setLoadUse(2'b10);
    #1;
    chk("lu_ctl", ctl, 6'b110010);
    @(negedge clk);
    clearInputs();
    bus.rd_m = 5'd7; bus.regwrite_m = 1'b1;
    bus.rs_e[AW +: AW] = 5'd7;
    #1;
    chk("lu_release_ctl", ctl, 6'b0);
    chk("lu_release_fwd", bus.fwd_e[3:2], 1);
    @(negedge clk);
    clearInputs();
    setLoadUse(2'b01);
    #1;
    chk("lu_unused_ctl", ctl, 6'b0);
    chk("lu_stall_cnt", bus.stall_cnt, 1);

    // redirect overrides load-use
    resetPulse();
    @(negedge clk);
    clearInputs();
    setLoadUse(2'b10);
    bus.pcsrc_e = 1'b1;
    #1;
    chk("br_lu_ctl", ctl, 6'b000110);
    @(negedge clk);
    clearInputs();
    #1;
    chk("br_flush_cnt", bus.flush_cnt, 1);
    chk("br_stall_cnt", bus.stall_cnt, 0);

    // multi-cycle: done four cycles after start
    resetPulse();
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      clearInputs();
      bus.mc_start_e = (c == 0);
      bus.mc_done    = (c == 4);
      #1;
      chk($sformatf("mc4_ctl_c%0d", c), ctl, (c < 4) ? MC_CTL : 6'b0);
    end
    @(negedge clk);
    clearInputs();
    #1;
    chk("mc4_idle_ctl", ctl, 6'b0);
    chk("mc4_stall_cnt", bus.stall_cnt, 4);
    bus.mc_start_e = 1'b1;
    bus.mc_done    = 1'b1;
    #1;
    chk("mc_same_cycle_ctl", ctl, 6'b0);

    // watchdog: no done, stall capped at TMO cycles, flag sticky
    resetPulse();
    for (int c = 0; c <= TMO; c++) begin
      @(negedge clk);
      clearInputs();
      bus.mc_start_e = (c == 0);
      #1;
      chk($sformatf("tmo_ctl_c%0d", c), ctl, (c < TMO) ? MC_CTL : 6'b0);
      chk($sformatf("tmo_flag_c%0d", c), bus.mc_timeout, 0);
    end
    @(negedge clk);
    clearInputs();
    #1;
    chk("tmo_flag_set", bus.mc_timeout, 1);
    chk("tmo_after_ctl", ctl, 6'b0);
    for (int c = 0; c <= 2; c++) begin
      @(negedge clk);
      clearInputs();
      bus.mc_start_e = (c == 0);
      bus.mc_done    = (c == 2);
      #1;
      chk($sformatf("tmo_second_ctl_c%0d", c), ctl, (c < 2) ? MC_CTL : 6'b0);
    end
    @(negedge clk);
    clearInputs();
    #1;
    chk("tmo_flag_held", bus.mc_timeout, 1);
    chk("tmo_stall_cnt", bus.stall_cnt, TMO + 2);

    // counter saturation under a 20-cycle stall
    resetPulse();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      clearInputs();
      setLoadUse(2'b10);
    end
    @(negedge clk);
    clearInputs();
    #1;
    chk("sat_stall_cnt", bus.stall_cnt, CNT_MAX);

    // asynchronous reset in the middle of a busy stall
    resetPulse();
    @(negedge clk);
    clearInputs();
    bus.mc_start_e = 1'b1;
    @(negedge clk);
    clearInputs();
    #1;
    chk("rstbusy_pre_ctl", ctl, MC_CTL);
    #1;
    rst = 1'b1;
    #1;
    chk("rstbusy_ctl", ctl, 6'b0);
    chk("rstbusy_stall_cnt", bus.stall_cnt, 0);
    chk("rstbusy_timeout", bus.mc_timeout, 0);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rstbusy_idle_ctl", ctl, 6'b0);

    // randomized run against the reference model
    resetPulse();
    mActive = 0; mAge = 0; mTimeout = 0; mStallCnt = 0; mFlushCnt = 0;
    repeat (400) randomCycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
